// File: rtl/ex_if.sv
// Execute-stage bus: ID-side controls and operands in, MEM-side results and stall out.
interface ex_if;
    logic        e_write_reg_i;
    logic        e_mem_to_reg_i;
    logic        e_write_mem_i;
    logic [4:0]  alu_op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [31:0] store_val_i;
    logic [4:0]  e_des_r_i;
    logic [2:0]  e_memc_i;
    logic        flush_i;
    logic [31:0] alu_result_o;
    logic [31:0] write_mem_val_o;
    logic        e_write_reg_o;
    logic        e_mem_to_reg_o;
    logic        e_write_mem_o;
    logic [4:0]  e_des_r_o;
    logic [2:0]  e_memc_o;
    logic        stall_o;

    modport master (
        output e_write_reg_i, e_mem_to_reg_i, e_write_mem_i, alu_op_i,
               src_a_i, src_b_i, store_val_i, e_des_r_i, e_memc_i, flush_i,
        input  alu_result_o, write_mem_val_o, e_write_reg_o, e_mem_to_reg_o,
               e_write_mem_o, e_des_r_o, e_memc_o, stall_o
    );

    modport slave (
        input  e_write_reg_i, e_mem_to_reg_i, e_write_mem_i, alu_op_i,
               src_a_i, src_b_i, store_val_i, e_des_r_i, e_memc_i, flush_i,
        output alu_result_o, write_mem_val_o, e_write_reg_o, e_mem_to_reg_o,
               e_write_mem_o, e_des_r_o, e_memc_o, stall_o
    );
endinterface

// File: rtl/ex.sv
// EX stage: single-cycle ALU with an optional HI/LO multiply/divide unit (EX_MULDIV_EN).
// Divides use a 32-step restoring divider that stalls upstream until its DONE cycle.
module ex (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    localparam int DATA_W = 32;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
`ifdef EX_MULDIV_EN
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
`endif

    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [4:0]               shamt;

    assign sa    = bus.src_a_i;
    assign sb    = bus.src_b_i;
    assign shamt = bus.src_b_i[4:0];

    logic [DATA_W-1:0] res_d;
    logic              res_vld_d;
    logic              take_d;
    logic              idle;

    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] write_mem_val_q;
    logic              e_write_reg_q;
    logic              e_mem_to_reg_q;
    logic              e_write_mem_q;
    logic [4:0]        e_des_r_q;
    logic [2:0]        e_memc_q;

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q;
    logic [5:0]        cnt_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvsr_q;
    logic [DATA_W-1:0] dvnd_raw_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic              div0_q;

    logic              is_div;
    logic              div_signed;
    logic [63:0]       prod_s;
    logic [63:0]       prod_u;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign is_div     = (bus.alu_op_i == OP_DIV) || (bus.alu_op_i == OP_DIVU);
    assign div_signed = (bus.alu_op_i == OP_DIV);
    // Low 64 bits of a 64x64 product do not depend on signedness, so extend then multiply.
    assign prod_s     = {{32{sa[DATA_W-1]}}, bus.src_a_i} * {{32{sb[DATA_W-1]}}, bus.src_b_i};
    assign prod_u     = {32'b0, bus.src_a_i} * {32'b0, bus.src_b_i};
    assign rem_sh     = {rem_q, quo_q[DATA_W-1]};
    assign rem_sub    = rem_sh - {1'b0, dvsr_q};
    assign idle       = (state_q == S_IDLE);

    assign bus.stall_o = !rst && !bus.flush_i &&
                         ((idle && is_div) || (state_q == S_BUSY));
`else
    assign idle        = 1'b1;
    assign bus.stall_o = 1'b0;
`endif

    always_comb begin
        res_d     = '0;
        res_vld_d = 1'b1;
        case (bus.alu_op_i)
            OP_ADD:  res_d = bus.src_a_i + bus.src_b_i;
            OP_SUB:  res_d = bus.src_a_i - bus.src_b_i;
            OP_AND:  res_d = bus.src_a_i & bus.src_b_i;
            OP_OR:   res_d = bus.src_a_i | bus.src_b_i;
            OP_XOR:  res_d = bus.src_a_i ^ bus.src_b_i;
            OP_NOR:  res_d = ~(bus.src_a_i | bus.src_b_i);
            OP_SLT:  res_d = {31'b0, (sa < sb)};
            OP_SLTU: res_d = {31'b0, (bus.src_a_i < bus.src_b_i)};
            OP_SLL:  res_d = bus.src_a_i << shamt;
            OP_SRL:  res_d = bus.src_a_i >> shamt;
            OP_SRA:  res_d = sa >>> shamt;
`ifdef EX_MULDIV_EN
            OP_MFHI: res_d = hi_q;
            OP_MFLO: res_d = lo_q;
`endif
            default: res_vld_d = 1'b0;
        endcase
    end

    // Only ALU and move-from ops in IDLE produce a real result; everything else is a bubble.
    assign take_d = res_vld_d && !bus.flush_i && idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q    <= '0;
            write_mem_val_q <= '0;
            e_write_reg_q   <= 1'b0;
            e_mem_to_reg_q  <= 1'b0;
            e_write_mem_q   <= 1'b0;
            e_des_r_q       <= '0;
            e_memc_q        <= '0;
        end else if (take_d) begin
            alu_result_q    <= res_d;
            write_mem_val_q <= bus.store_val_i;
            e_write_reg_q   <= bus.e_write_reg_i;
            e_mem_to_reg_q  <= bus.e_mem_to_reg_i;
            e_write_mem_q   <= bus.e_write_mem_i;
            e_des_r_q       <= bus.e_des_r_i;
            e_memc_q        <= bus.e_memc_i;
        end else begin
            alu_result_q    <= '0;
            write_mem_val_q <= '0;
            e_write_reg_q   <= 1'b0;
            e_mem_to_reg_q  <= 1'b0;
            e_write_mem_q   <= 1'b0;
            e_des_r_q       <= '0;
            e_memc_q        <= '0;
        end
    end

    assign bus.alu_result_o    = alu_result_q;
    assign bus.write_mem_val_o = write_mem_val_q;
    assign bus.e_write_reg_o   = e_write_reg_q;
    assign bus.e_mem_to_reg_o  = e_mem_to_reg_q;
    assign bus.e_write_mem_o   = e_write_mem_q;
    assign bus.e_des_r_o       = e_des_r_q;
    assign bus.e_memc_o        = e_memc_q;

`ifdef EX_MULDIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (bus.flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (is_div) begin
                        state_q <= (bus.src_b_i == '0) ? S_DONE : S_BUSY;
                    end else if (bus.alu_op_i == OP_MULT) begin
                        {hi_q, lo_q} <= prod_s;
                    end else if (bus.alu_op_i == OP_MULTU) begin
                        {hi_q, lo_q} <= prod_u;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    if (div0_q) begin
                        lo_q <= '1;
                        hi_q <= dvnd_raw_q;
                    end else begin
                        lo_q <= cond_neg(quo_q, neg_quo_q);
                        hi_q <= cond_neg(rem_q, neg_rem_q);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Divider datapath: operands reload every idle cycle, one restoring step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            dvnd_raw_q <= bus.src_a_i;
            div0_q     <= (bus.src_b_i == '0);
            neg_quo_q  <= div_signed && (bus.src_a_i[DATA_W-1] ^ bus.src_b_i[DATA_W-1]);
            neg_rem_q  <= div_signed && bus.src_a_i[DATA_W-1];
            quo_q      <= div_signed ? abs_val(sa) : bus.src_a_i;
            dvsr_q     <= div_signed ? abs_val(sb) : bus.src_b_i;
            rem_q      <= '0;
        end else if (state_q == S_BUSY) begin
            if (!rem_sub[DATA_W]) begin
                rem_q <= rem_sub[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: directed corner cases plus randomized ops against a behavioural model.
module tb_ex;
    logic clk = 1'b0;
    logic rst = 1'b0;

    ex_if bus();

    ex dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_wr"},  64'(bus.e_write_reg_o),  64'd0);
        check({tag, "_m2r"}, 64'(bus.e_mem_to_reg_o), 64'd0);
        check({tag, "_wm"},  64'(bus.e_write_mem_o),  64'd0);
        check({tag, "_res"}, 64'(bus.alu_result_o),   64'd0);
    endtask

    function automatic logic ref_alu(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r);
        int ia;
        int ib;
        int sh;
        ia = a;
        ib = b;
        sh = int'(b[4:0]);
        r  = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = (ia < ib) ? 32'd1 : 32'd0;
            5'd7:  r = (a < b) ? 32'd1 : 32'd0;
            5'd8:  r = a << sh;
            5'd9:  r = a >> sh;
            5'd10: r = ia >>> sh;
`ifdef EX_MULDIV_EN
            5'd15: r = m_hi;
            5'd16: r = m_lo;
`endif
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic rand_ctl();
        bus.e_write_reg_i  = 1'($urandom);
        bus.e_mem_to_reg_i = 1'($urandom);
        bus.e_write_mem_i  = 1'($urandom);
        bus.store_val_i    = $urandom;
        bus.e_des_r_i      = 5'($urandom);
        bus.e_memc_i       = 3'($urandom);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives one op and checks its outcome; divides are followed through their stall and DONE cycle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        logic [31:0] r;
        logic        v;
        int          n;
        int          ia;
        int          ib;
        longint      la;
        longint      lb;
        longint      lq;
        bus.alu_op_i = op;
        bus.src_a_i  = a;
        bus.src_b_i  = b;
        bus.flush_i  = fl;
        v  = ref_alu(op, a, b, r);
        ia = a;
        ib = b;
        la = ia;
        lb = ib;
        #1;
`ifdef EX_MULDIV_EN
        if ((op == 5'd13 || op == 5'd14) && !fl) begin
            n = 0;
            while (bus.stall_o === 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
                check_bubble("div_busy");
            end
            check("div_stall_cycles", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
            @(posedge clk);
            #1;
            check_bubble("div_done");
            if (b == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else if (op == 5'd14) begin
                m_lo = a / b;
                m_hi = a % b;
            end else begin
                lq   = la / lb;
                m_lo = lq[31:0];
                lq   = la % lb;
                m_hi = lq[31:0];
            end
            return;
        end
`endif
        check("stall_low", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        #1;
        if (v && !fl) begin
            check("result",   64'(bus.alu_result_o),    64'(r));
            check("wr",       64'(bus.e_write_reg_o),   64'(bus.e_write_reg_i));
            check("m2r",      64'(bus.e_mem_to_reg_o),  64'(bus.e_mem_to_reg_i));
            check("wm",       64'(bus.e_write_mem_o),   64'(bus.e_write_mem_i));
            check("store",    64'(bus.write_mem_val_o), 64'(bus.store_val_i));
            check("des",      64'(bus.e_des_r_o),       64'(bus.e_des_r_i));
            check("memc",     64'(bus.e_memc_o),        64'(bus.e_memc_i));
        end else begin
            check_bubble(fl ? "flush" : "nop");
        end
`ifdef EX_MULDIV_EN
        if (!fl && op == 5'd11) begin
            lq = la * lb;
            {m_hi, m_lo} = 64'(lq);
        end else if (!fl && op == 5'd12) begin
            {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
        end
`endif
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        fl;

        rand_ctl();
        bus.alu_op_i = 5'd13;
        bus.src_a_i  = 32'd9;
        bus.src_b_i  = 32'd3;
        bus.flush_i  = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_res",   64'(bus.alu_result_o),    64'd0);
        check("rst_store", 64'(bus.write_mem_val_o), 64'd0);
        check("rst_wr",    64'(bus.e_write_reg_o),   64'd0);
        check("rst_des",   64'(bus.e_des_r_o),       64'd0);
        check("rst_stall", 64'(bus.stall_o),         64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        bus.e_write_reg_i = 1'b1;
        bus.e_des_r_i     = 5'd3;
        do_op(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("add_wrap", 64'(bus.alu_result_o), 64'd0);
        check("add_des",  64'(bus.e_des_r_o),    64'd3);
        check("add_wr",   64'(bus.e_write_reg_o), 64'd1);
        do_op(5'd10, 32'h8000_0000, 32'd4, 1'b0);
        check("sra", 64'(bus.alu_result_o), 64'h0000_0000_F800_0000);
        do_op(5'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("slt", 64'(bus.alu_result_o), 64'd1);
        do_op(5'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("sltu", 64'(bus.alu_result_o), 64'd0);
        do_op(5'd0, 32'd5, 32'd6, 1'b1);
        do_op(5'd20, 32'd5, 32'd6, 1'b0);

`ifdef EX_MULDIV_EN
        do_op(5'd13, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("div_lo", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFD);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("div_hi", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFF);
        do_op(5'd14, 32'd5, 32'd0, 1'b0);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("div0_lo", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFF);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("div0_hi", 64'(bus.alu_result_o), 64'd5);
        do_op(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("divovf_lo", 64'(bus.alu_result_o), 64'h0000_0000_8000_0000);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("divovf_hi", 64'(bus.alu_result_o), 64'd0);
        do_op(5'd12, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("multu_hi", 64'(bus.alu_result_o), 64'd1);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("multu_lo", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFE);
        do_op(5'd11, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("mult_hi", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFF);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("mult_lo", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFE);
        do_op(5'd13, 32'd100, 32'd7, 1'b1);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);

        // Flush ten cycles into a divide: stall drops at once and HI/LO keep the MULT result.
        bus.alu_op_i = 5'd13;
        bus.src_a_i  = 32'd100;
        bus.src_b_i  = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        check("busy_stall", 64'(bus.stall_o), 64'd1);
        bus.flush_i = 1'b1;
        #1;
        check("flush_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        #1;
        bus.flush_i  = 1'b0;
        bus.alu_op_i = 5'd31;
        check_bubble("flush_busy");
        #1;
        check("post_flush_stall", 64'(bus.stall_o), 64'd0);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("flush_keeps_lo", 64'(bus.alu_result_o), 64'h0000_0000_FFFF_FFFE);

        bus.alu_op_i = 5'd13;
        bus.src_a_i  = 32'd1000;
        bus.src_b_i  = 32'd3;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_stall", 64'(bus.stall_o), 64'd0);
        check_bubble("rstmid");
        @(posedge clk);
        #1;
        bus.alu_op_i = 5'd31;
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
        check("rst_hi", 64'(bus.alu_result_o), 64'd0);
        do_op(5'd16, 32'd0, 32'd0, 1'b0);
        check("rst_lo", 64'(bus.alu_result_o), 64'd0);
`else
        do_op(5'd11, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(5'd13, 32'd7, 32'd2, 1'b0);
        do_op(5'd15, 32'd0, 32'd0, 1'b0);
`endif

        for (int i = 0; i < 300; i++) begin
            rand_ctl();
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(11, 16)) : 5'($urandom);
            a  = rand_opnd();
            b  = rand_opnd();
            fl = ($urandom_range(0, 7) == 0);
            do_op(op, a, b, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex.md
EX -- requirements
Module: ex

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  asynchronous reset, active-high.
REQ-003 e_write_reg_i / e_mem_to_reg_i / e_write_mem_i  input  1 each  control flags from ID.
REQ-004 alu_op_i  input  5  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI, 16 MFLO, others NOP.
REQ-005 src_a_i, src_b_i  input  32  operands; shifts shift src_a_i by src_b_i[4:0].
REQ-006 store_val_i  input  32  store data; e_des_r_i  input  5  destination reg; e_memc_i  input  3  memory access class.
REQ-007 flush_i  input  1  kill current op.
REQ-008 alu_result_o, write_mem_val_o  output  32  to MEM.
REQ-009 e_write_reg_o, e_mem_to_reg_o, e_write_mem_o  output  1 each; e_des_r_o  output  5; e_memc_o  output  3.
REQ-010 stall_o  output  1  combinational; high = upstream holds all inputs stable.

Function
REQ-011 Non-stalling ops register result and pass-through fields on the next posedge (latency 1).
REQ-012 ADD/SUB wrap modulo 2^32; no overflow trap.
REQ-013 SLT signed, SLTU unsigned; result 1 or 0 zero-extended.
REQ-014 MULT/MULTU write the 64-bit product to {HI,LO} in one cycle; outputs form a bubble.
REQ-015 Bubble = e_write_reg_o, e_mem_to_reg_o, e_write_mem_o all 0; alu_result_o 0.
REQ-016 DIV/DIVU use FSM IDLE -> BUSY -> DONE -> IDLE; restoring divide, one quotient bit per cycle, 32 BUSY cycles, 6-bit counter.
REQ-017 stall_o high while IDLE-with-DIV/DIVU-input and throughout BUSY; low in DONE.
REQ-018 DONE writes LO=quotient, HI=remainder; DIV: quotient sign = XOR of operand signs, remainder sign = dividend sign.
REQ-019 Divide-by-zero: no BUSY; IDLE -> DONE next cycle, LO=32'hFFFFFFFF, HI=src_a_i.
REQ-020 DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0.
REQ-021 Outputs are bubbles during all divide cycles, including DONE.
REQ-022 MFHI/MFLO return HI/LO; a MFHI/MFLO issued right after DONE sees new values.
REQ-023 flush_i has priority over everything: next posedge outputs bubble, FSM IDLE, counter 0, HI/LO unchanged, stall_o drops same cycle.
REQ-024 flush_i coincident with DIV issue: divide not started.
REQ-025 NOP op yields bubble.

Reset
REQ-026 rst asserted: all outputs 0 immediately, HI=LO=0, FSM IDLE, counter 0, stall_o 0.
REQ-027 rst mid-divide: divide abandoned, no HI/LO update on release.

Configuration
REQ-028 Macro EX_MULDIV_EN: defined -> REQ-014..REQ-022 as stated.
REQ-029 EX_MULDIV_EN undefined -> MULT..MFLO treated as NOP, no HI/LO or FSM logic, stall_o tied 0.

Verification
REQ-030 ADD 32'hFFFFFFFF+1, dest 3, write_reg=1 -> next cycle alu_result_o=0, e_des_r_o=3, e_write_reg_o=1.
REQ-031 SRA 32'h80000000 by 4; SLT -1,1 -> 32'hF8000000, then 1.
REQ-032 DIV -7/2 -> stall_o high 33 cycles, then MFLO=32'hFFFFFFFD, MFHI=32'hFFFFFFFF.
REQ-033 DIVU 5/0 -> stall_o high 1 cycle; MFLO=32'hFFFFFFFF, MFHI=5.
REQ-034 MULT 32'hFFFFFFFF*2 -> MFHI=32'hFFFFFFFF, MFLO=32'hFFFFFFFE; MULTU same operands -> MFHI=1, MFLO=32'hFFFFFFFE.
REQ-035 flush_i at BUSY cycle 10, then rst pulse during new DIV -> stall_o 0, bubbles, HI/LO unchanged then 0.
